// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//   Shared types and helpers for the pipelined barrel shifter.
//   - shift_op_t : shift mode carried through the pipeline
//   - clog2      : ceiling log2, used for level count and shift-amount width
//   - stage_t    : everything one mux level hands to the next. Fields are
//                  sized for the largest supported shifter (MAX_WIDTH); a
//                  shifter instance uses only the low WIDTH / LEVELS bits and
//                  keeps the unused upper bits at zero.
//   Optional feature macro: SHIFT_STICKY_EN (consumed by the modules that
//   import this package; the struct always carries the sticky field).
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_LEVELS = 6;

    typedef enum logic [1:0] {
        LOGIC  = 2'd0,
        ARITH  = 2'd1,
        ROTATE = 2'd2
    } shift_op_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MAX_WIDTH-1:0]  bits;
        logic [MAX_LEVELS-1:0] shift_rem;
        logic                  dir;
        shift_op_t             op;
        logic                  fill;
        logic                  sticky;
    } stage_t;

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//   One mux level of the barrel shifter: shifts by 2^LEVEL when bit LEVEL of
//   the carried shift amount is set, in the carried direction and mode.
//   With REGISTERED=1 the result is captured in a stall-aware register
//   (valid bit always follows the pipeline, data only loads for valid beats);
//   with REGISTERED=0 the level is purely combinational.
//   Optional feature macro: SHIFT_STICKY_EN (accumulate bits dropped by
//   right LOGIC/ARITH shifts into the sticky field).
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   in_stage  in   stage_t from the previous level (or the input port)
//   stall     in   hold every register of this level
//   out_stage out  stage_t to the next level
// ---------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEVEL      = 0,
    parameter int REGISTERED = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t in_stage,
    input  logic   stall,
    output stage_t out_stage
);

    localparam int SHAMT = 1 << LEVEL;

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pad;
    logic [WIDTH-1:0] shifted;
    logic             do_shift;
    logic             is_rot;
    stage_t           nxt;
    logic             unused_in;
`ifdef SHIFT_STICKY_EN
    logic             dropped;
`endif

    // Upper struct bits beyond WIDTH/LEVEL are carried as zero and not read.
    assign unused_in = ^{in_stage};

    always_comb begin
        data     = in_stage.bits[WIDTH-1:0];
        do_shift = in_stage.shift_rem[LEVEL];
        is_rot   = (in_stage.op == ROTATE);
        pad      = '0;
        shifted  = data;
        if (do_shift) begin
            if (in_stage.dir) begin
                // Left: bits entering at the bottom are the wrapped top bits
                // for ROTATE, zero otherwise.
                pad     = is_rot ? data : '0;
                shifted = WIDTH'({data, pad} >> (WIDTH - SHAMT));
            end else begin
                // Right: fill is the original MSB for ARITH, 0 for LOGIC.
                pad     = is_rot ? data : {WIDTH{in_stage.fill}};
                shifted = WIDTH'({pad, data} >> SHAMT);
            end
        end
        nxt      = in_stage;
        nxt.bits = MAX_WIDTH'(shifted);
`ifdef SHIFT_STICKY_EN
        dropped    = do_shift && !in_stage.dir && !is_rot && (|data[SHAMT-1:0]);
        nxt.sticky = in_stage.sticky | dropped;
`else
        nxt.sticky = 1'b0;
`endif
    end

    generate
        if (REGISTERED != 0) begin : g_reg
            logic                  vld_p1;
            logic [WIDTH-1:0]      bits_p1;
            logic [MAX_LEVELS-1:0] shift_rem_p1;
            logic                  dir_p1;
            shift_op_t             op_p1;
            logic                  fill_p1;
            logic                  sticky_p1;

            // ---- stage register: valid ----
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_p1 <= 1'b0;
                end else if (!stall) begin
                    vld_p1 <= nxt.valid;
                end
            end

            // ---- stage register: data, loads only for valid beats ----
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bits_p1      <= '0;
                    shift_rem_p1 <= '0;
                    dir_p1       <= 1'b0;
                    op_p1        <= LOGIC;
                    fill_p1      <= 1'b0;
                end else if (!stall && nxt.valid) begin
                    bits_p1      <= shifted;
                    shift_rem_p1 <= nxt.shift_rem;
                    dir_p1       <= nxt.dir;
                    op_p1        <= nxt.op;
                    fill_p1      <= nxt.fill;
                end
            end

`ifdef SHIFT_STICKY_EN
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sticky_p1 <= 1'b0;
                end else if (!stall && nxt.valid) begin
                    sticky_p1 <= nxt.sticky;
                end
            end
`else
            assign sticky_p1 = 1'b0;
`endif

            always_comb begin
                out_stage           = '0;
                out_stage.valid     = vld_p1;
                out_stage.bits      = MAX_WIDTH'(bits_p1);
                out_stage.shift_rem = shift_rem_p1;
                out_stage.dir       = dir_p1;
                out_stage.op        = op_p1;
                out_stage.fill      = fill_p1;
                out_stage.sticky    = sticky_p1;
            end
        end else begin : g_comb
            logic unused_ctl;
            assign unused_ctl = clk ^ rst ^ stall;
            assign out_stage  = nxt;
        end
    endgenerate

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//   Pipelined bidirectional barrel shifter (LOGIC / ARITH / ROTATE) with a
//   valid/ready stream interface. LEVELS = clog2(WIDTH) mux levels; a
//   register follows every REG_EVERY levels and always the last one, giving
//   a latency of ceil(LEVELS/REG_EVERY) cycles. Backpressure freezes the
//   whole pipeline (bubbles included) while the output beat is not taken.
//   Optional feature macro: SHIFT_STICKY_EN (adds out_sticky).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid && in_ready
//   in_bits    in   data to shift
//   in_shift   in   shift amount 0..WIDTH-1
//   in_dir     in   0 = right, 1 = left
//   in_op      in   0 LOGIC, 1 ARITH, 2 ROTATE, 3 treated as LOGIC
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the output beat
//   out_bits   out  shifted result
//   out_sticky out  OR of bits dropped by right LOGIC/ARITH (SHIFT_STICKY_EN)
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int REG_EVERY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_bits,
    input  logic [clog2(WIDTH)-1:0] in_shift,
    input  logic                    in_dir,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_bits
`ifdef SHIFT_STICKY_EN
    ,
    output logic                    out_sticky
`endif
);

    localparam int LEVELS = clog2(WIDTH);

    stage_t stage_in;
    stage_t stage_p [0:LEVELS];
    logic   stall;
    logic   unused_last;

    // Only the output beat can block; everything upstream moves in lockstep.
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    always_comb begin
        stage_in           = '0;
        stage_in.valid     = in_valid;
        stage_in.bits      = MAX_WIDTH'(in_bits);
        stage_in.shift_rem = MAX_LEVELS'(in_shift);
        stage_in.dir       = in_dir;
        stage_in.op        = (in_op == 2'd3) ? LOGIC : shift_op_t'(in_op);
        // Arithmetic fill is the sign of the original operand, captured once
        // here so later levels do not see an already-shifted MSB.
        stage_in.fill      = !in_dir && (stage_in.op == ARITH) && in_bits[WIDTH-1];
        stage_in.sticky    = 1'b0;
    end

    assign stage_p[0] = stage_in;

    generate
        for (genvar k = 0; k < LEVELS; k++) begin : g_level
            localparam int REG_K = (((k + 1) % REG_EVERY) == 0 || k == LEVELS - 1) ? 1 : 0;
            shift_stage #(
                .WIDTH     (WIDTH),
                .LEVEL     (k),
                .REGISTERED(REG_K)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .in_stage (stage_p[k]),
                .stall    (stall),
                .out_stage(stage_p[k+1])
            );
        end
    endgenerate

    assign out_valid   = stage_p[LEVELS].valid;
    assign out_bits    = stage_p[LEVELS].bits[WIDTH-1:0];
    assign unused_last = ^{stage_p[LEVELS]};
`ifdef SHIFT_STICKY_EN
    assign out_sticky  = stage_p[LEVELS].sticky;
`endif

endmodule
